// File: rtl/joypad_io_if.sv
// rtl/joypad_io_if.sv - strobed CPU register port for the $4016/$4017 controller registers
interface joypad_io_if;
  logic       io_sel;
  logic       io_en;
  logic       io_rw;
  logic [7:0] io_data_in;
  logic [7:0] io_data_out;
  logic [7:0] bus_last;

  modport master (
    output io_sel, io_en, io_rw, io_data_in, bus_last,
    input  io_data_out
  );

  modport slave (
    input  io_sel, io_en, io_rw, io_data_in, bus_last,
    output io_data_out
  );
endinterface

// File: rtl/joypad_io.sv
// rtl/joypad_io.sv - $4016/$4017 responder: latches two pads on strobe, shifts one bit per read
// Per-pad turbo on A/B gated by a frame-tick driven phase.
module joypad_io #(
  parameter int SYNC_STAGES  = 2,
  parameter int TURBO_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clk_en,
  input  logic       frame_tick,
  input  logic [7:0] pad1_btn,
  input  logic [7:0] pad2_btn,
  input  logic [1:0] pad1_turbo,
  input  logic [1:0] pad2_turbo,
  joypad_io_if.slave io
);
  localparam int CW = (TURBO_FRAMES > 1) ? $clog2(TURBO_FRAMES) : 1;
  localparam int SW = 20;
  localparam logic [CW-1:0] CNT_LAST = CW'(TURBO_FRAMES - 1);

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_out;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    shift1_q, shift1_d;
  logic [7:0]    shift2_q, shift2_d;
  logic [7:0]    eff1, eff2;
  logic          acc;
  logic          unused_bits;

  function automatic logic [7:0] apply_turbo(input logic [7:0] b, input logic [1:0] t,
                                             input logic ph);
    apply_turbo = b;
    if (t[0]) apply_turbo[0] = b[0] & ph;
    if (t[1]) apply_turbo[1] = b[1] & ph;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pad2_turbo, pad1_turbo, pad2_btn, pad1_btn};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Registered phase is used, so a reload coincident with frame_tick sees the pre-toggle value.
  assign eff1 = apply_turbo(sync_out[7:0],  sync_out[17:16], phase_q);
  assign eff2 = apply_turbo(sync_out[15:8], sync_out[19:18], phase_q);
  assign acc  = cpu_clk_en & io.io_en;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    strobe_d = strobe_q;
    shift1_d = shift1_q;
    shift2_d = shift2_q;
    if (acc && io.io_rw && !io.io_sel) strobe_d = io.io_data_in[0];
    if (strobe_q) begin
      shift1_d = eff1;
      shift2_d = eff2;
    end else if (acc && !io.io_rw) begin
      if (io.io_sel) shift2_d = {1'b1, shift2_q[7:1]};
      else           shift1_d = {1'b1, shift1_q[7:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      phase_q  <= 1'b0;
      strobe_q <= 1'b0;
      shift1_q <= 8'h00;
      shift2_q <= 8'h00;
    end else begin
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
      shift1_q <= shift1_d;
      shift2_q <= shift2_d;
    end
  end

  assign io.io_data_out = {io.bus_last[7:5], 4'b0000,
                           io.io_sel ? shift2_q[0] : shift1_q[0]};
  assign unused_bits = ^{io.io_data_in[7:1], io.bus_last[4:0]};
endmodule
